localbus_master: RTL and testbench

LOCALBUS_MASTER -- requirements
Module: localbus_master

---
 rtl/localbus_master.sv | 155 +++++++++++++++
 tb/tb_localbus_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/localbus_master.sv
// rtl/localbus_master.sv - two-phase localbus master for 36-bit lookup-table entries.
// Optional CS/REL timeout is built when LOCALBUS_MASTER_TIMEOUT_EN is defined.
module localbus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd_wr,
  input  logic [2:0]  cmd_table,
  input  logic [8:0]  cmd_entry,
  input  logic [35:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [35:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        localbus_ale,
  output logic        localbus_rd_wr,
  output logic        localbus_cs_n,
  output logic [31:0] localbus_data,
  input  logic        localbus_ack_n,
  input  logic [31:0] localbus_data_out
);

  typedef enum logic [2:0] {S_IDLE, S_ALE, S_CS, S_REL, S_GAP, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        phase_q;
  logic        rd_wr_q;
  logic [2:0]  table_q;
  logic [8:0]  entry_q;
  logic [35:0] wdata_q;
  logic [35:0] rdata_q;
  logic        ack_seen;
  logic        tmo_fire;
  logic [31:0] addr;

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("localbus_master: TIMEOUT_CYCLES out of range 1..65535");
    end
  endgenerate

  assign ack_seen = !localbus_ack_n;
  assign addr     = {17'b0, table_q, entry_q, 2'b0, phase_q};

`ifdef LOCALBUS_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt;
  logic        tmo_q;

  // Fires only while still waiting on the ack edge the current state needs.
  assign tmo_fire = (tmo_cnt == TMO_LAST) &&
                    (((state == S_CS) && !ack_seen) || ((state == S_REL) && ack_seen));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (state_nxt != state)
        tmo_cnt <= '0;
      else if (state == S_CS || state == S_REL)
        tmo_cnt <= tmo_cnt + 16'd1;
      if (state == S_IDLE && cmd_valid)
        tmo_q <= 1'b0;
      else if (tmo_fire)
        tmo_q <= 1'b1;
    end
  end

  assign rsp_timeout = (state == S_DONE) && tmo_q;
`else
  assign tmo_fire    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      phase_q <= 1'b0;
      rd_wr_q <= 1'b0;
      table_q <= '0;
      entry_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && cmd_valid) begin
        phase_q <= 1'b0;
        rd_wr_q <= cmd_rd_wr;
        table_q <= cmd_table;
        entry_q <= cmd_entry;
        wdata_q <= cmd_wdata;
        rdata_q <= '0;
      end else if (state == S_GAP) begin
        phase_q <= 1'b1;
      end else if (tmo_fire) begin
        rdata_q <= '0;
      end else if (state == S_CS && ack_seen && rd_wr_q) begin
        if (phase_q)
          rdata_q[31:0] <= localbus_data_out;
        else
          rdata_q[35:32] <= localbus_data_out[3:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_valid) state_nxt = S_ALE;
      S_ALE:  state_nxt = S_CS;
      S_CS: begin
        if (ack_seen)      state_nxt = S_REL;
        else if (tmo_fire) state_nxt = S_DONE;
      end
      S_REL: begin
        if (!ack_seen)     state_nxt = phase_q ? S_DONE : S_GAP;
        else if (tmo_fire) state_nxt = S_DONE;
      end
      S_GAP:  state_nxt = S_ALE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset idles the bus immediately.
  always_comb begin
    localbus_ale   = 1'b0;
    localbus_cs_n  = 1'b1;
    localbus_rd_wr = 1'b0;
    localbus_data  = '0;
    case (state)
      S_ALE: begin
        localbus_ale   = 1'b1;
        localbus_rd_wr = rd_wr_q;
        localbus_data  = addr;
      end
      S_CS: begin
        localbus_cs_n  = 1'b0;
        localbus_rd_wr = rd_wr_q;
        if (!rd_wr_q)
          localbus_data = phase_q ? wdata_q[31:0] : {28'b0, wdata_q[35:32]};
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign rsp_rdata = (state == S_DONE) ? rdata_q : 36'b0;

endmodule

// File: tb/tb_localbus_master.sv
// tb/tb_localbus_master.sv - randomized self-checking bench for localbus_master.
// Timeout scenario runs only when LOCALBUS_MASTER_TIMEOUT_EN is defined.
module tb_localbus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd_wr;
  logic [2:0]  cmd_table;
  logic [8:0]  cmd_entry;
  logic [35:0] cmd_wdata;
  logic        rsp_valid;
  logic [35:0] rsp_rdata;
  logic        rsp_timeout;
  logic        localbus_ale;
  logic        localbus_rd_wr;
  logic        localbus_cs_n;
  logic [31:0] localbus_data;
  logic        localbus_ack_n;
  logic [31:0] localbus_data_out;

  localbus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
    .cmd_table(cmd_table), .cmd_entry(cmd_entry), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .localbus_ale(localbus_ale), .localbus_rd_wr(localbus_rd_wr),
    .localbus_cs_n(localbus_cs_n), .localbus_data(localbus_data),
    .localbus_ack_n(localbus_ack_n), .localbus_data_out(localbus_data_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder: acks after resp_delay CS cycles (negative = never), data by latched phase.
  int          resp_delay = 0;
  int          cs_cyc;
  logic [31:0] rdat0, rdat1;
  logic        rsp_ph;

  always @(posedge clk or negedge reset) begin
    if (!reset) cs_cyc <= 0;
    else if (localbus_cs_n) cs_cyc <= 0;
    else cs_cyc <= cs_cyc + 1;
  end
  always @(posedge clk) if (localbus_ale) rsp_ph <= localbus_data[0];

  assign localbus_ack_n    = !(!localbus_cs_n && resp_delay >= 0 && cs_cyc >= resp_delay);
  assign localbus_data_out = rsp_ph ? rdat1 : rdat0;

  // Bus monitor.
  logic [31:0] ale_q[$];
  logic        rdwr_q[$];
  logic [31:0] csd_q[$];
  int          cs_run = 0, last_cs_len = 0, rsp_cnt = 0;
  int          overlap_viol = 0, idle_viol = 0, busy_ready = 0;
  logic        prev_cs_n = 1'b1;

  always @(negedge clk) begin
    if (localbus_ale) begin
      ale_q.push_back(localbus_data);
      rdwr_q.push_back(localbus_rd_wr);
    end
    if (!localbus_cs_n && prev_cs_n) csd_q.push_back(localbus_data);
    if (!reset) cs_run = 0;
    else if (!localbus_cs_n) cs_run++;
    else if (!prev_cs_n) begin
      last_cs_len = cs_run;
      cs_run = 0;
    end
    if (localbus_ale && !localbus_cs_n) overlap_viol++;
    if (!localbus_ale && localbus_cs_n && (localbus_data != 0 || localbus_rd_wr)) idle_viol++;
    if (rsp_valid) rsp_cnt++;
    prev_cs_n = localbus_cs_n;
  end

  // Reference expectations for the command in flight.
  logic        e_rd;
  logic [2:0]  e_tbl;
  logic [8:0]  e_ent;
  logic [35:0] e_wd;
  logic [63:0] e_rdata;
  logic [63:0] e_bus_wr[2];

  function automatic logic [31:0] exp_addr(input logic [2:0] t, input logic [8:0] e, input int ph);
    return 32'(int'(t) * 4096 + int'(e) * 8 + ph);
  endfunction

  task automatic set_expect(input logic rd, input logic [2:0] tbl, input logic [8:0] ent,
                            input logic [35:0] wd, input int dly,
                            input logic [31:0] d0, input logic [31:0] d1);
    ale_q.delete();
    rdwr_q.delete();
    csd_q.delete();
    e_rd = rd; e_tbl = tbl; e_ent = ent; e_wd = wd;
    resp_delay = dly; rdat0 = d0; rdat1 = d1;
    e_rdata     = ({32'b0, d0} % 16) * 64'h1_0000_0000 + {32'b0, d1};
    e_bus_wr[0] = {28'b0, wd} / 64'h1_0000_0000;
    e_bus_wr[1] = {28'b0, wd} % 64'h1_0000_0000;
  endtask

  task automatic drive_fields(input logic rd, input logic [2:0] tbl, input logic [8:0] ent,
                              input logic [35:0] wd);
    cmd_rd_wr = rd; cmd_table = tbl; cmd_entry = ent; cmd_wdata = wd;
  endtask

  task automatic start_cmd(input logic rd, input logic [2:0] tbl, input logic [8:0] ent,
                           input logic [35:0] wd, input int dly,
                           input logic [31:0] d0, input logic [31:0] d1, input bit hold);
    int waited;
    set_expect(rd, tbl, ent, wd, dly, d0, d1);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    drive_fields(rd, tbl, ent, wd);
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    check("accept_ready", cmd_ready, 1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Lat counts the acceptance cycle as 1 through the rsp_valid cycle inclusive.
  task automatic finish_cmd(input bit chk_lat, input bit exp_tmo);
    int lat = 1;
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        seen = 1;
        break;
      end
      if (cmd_ready) busy_ready++;
    end
    #1;
    check("rsp_seen", seen, 1);
    if (chk_lat) check("latency", lat, 9);
    check("rsp_timeout", rsp_timeout, exp_tmo);
    check("rsp_rdata", rsp_rdata, (e_rd && !exp_tmo) ? e_rdata : 64'd0);
    check("ready_in_done", cmd_ready, 0);
    if (exp_tmo) begin
      check("tmo_ale_count", ale_q.size(), 1);
      check("tmo_cs_len", last_cs_len, 16);
    end else begin
      check("ale_count", ale_q.size(), 2);
      check("cs_count", csd_q.size(), 2);
      if (ale_q.size() == 2 && csd_q.size() == 2) begin
        for (int ph = 0; ph < 2; ph++) begin
          check($sformatf("ale_addr_p%0d", ph), ale_q[ph], exp_addr(e_tbl, e_ent, ph));
          check($sformatf("ale_rdwr_p%0d", ph), rdwr_q[ph], e_rd);
          check($sformatf("cs_data_p%0d", ph), csd_q[ph], e_rd ? 64'd0 : e_bus_wr[ph]);
        end
      end
    end
  endtask

  task automatic after_rsp();
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid, 0);
    check("ready_after", cmd_ready, 1);
  endtask

  task automatic run_cmd(input logic rd, input logic [2:0] tbl, input logic [8:0] ent,
                         input logic [35:0] wd, input int dly,
                         input logic [31:0] d0, input logic [31:0] d1);
    start_cmd(rd, tbl, ent, wd, dly, d0, d1, 0);
    finish_cmd(dly == 0, 0);
    after_rsp();
  endtask

  initial begin
    int rc, k;
    reset = 1'b0;
    cmd_valid = 1'b0;
    drive_fields(0, 0, 0, 0);
    rdat0 = 0; rdat1 = 0;
    #2;
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cs_n", localbus_cs_n, 1);
    check("rst_ale", localbus_ale, 0);
    check("rst_data", localbus_data, 0);
    check("rst_rdata", rsp_rdata, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    run_cmd(0, 3'd5, 9'h1A3, 36'hADEADBEEF, 2, 32'h0, 32'h0);
    run_cmd(1, 3'd0, 9'h000, 36'h0, 1, 32'h00000007, 32'h12345678);
    run_cmd(1, 3'd7, 9'h1FF, 36'h0, 0, 32'hFFFFFFF9, 32'hCAFEF00D);
    run_cmd(0, 3'd2, 9'h0AA, 36'h123456789, 0, 32'h0, 32'h0);

    for (int n = 0; n < 10; n++) begin
      run_cmd(1'($urandom_range(0, 1)), 3'($urandom), 9'($urandom),
              {4'($urandom), 32'($urandom)}, int'($urandom_range(0, 3)),
              32'($urandom), 32'($urandom));
    end

    // Command valid held across two commands.
    start_cmd(0, 3'd1, 9'h011, 36'h9_0000_0001, 0, 32'h0, 32'h0, 1);
    drive_fields(1, 3'd6, 9'h122, 36'h0);
    finish_cmd(1, 0);
    set_expect(1, 3'd6, 9'h122, 36'h0, 0, 32'h0000000C, 32'h89ABCDEF);
    @(negedge clk);
    check("hold_idle_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    finish_cmd(1, 0);
    after_rsp();

    // Reset in the middle of the P1 chip-select phase.
    start_cmd(0, 3'd3, 9'h055, 36'h5_A5A5_A5A5, 6, 32'h0, 32'h0, 0);
    k = 0;
    @(negedge clk); #1;
    while (!(ale_q.size() == 2 && !localbus_cs_n) && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check("reach_p1_cs", localbus_cs_n, 0);
    rc = rsp_cnt;
    reset = 1'b0;
    #1;
    check("arst_cs_n", localbus_cs_n, 1);
    check("arst_ale", localbus_ale, 0);
    check("arst_data", localbus_data, 0);
    check("arst_rd_wr", localbus_rd_wr, 0);
    check("arst_ready", cmd_ready, 1);
    check("arst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("no_rsp_after_reset", rsp_cnt, rc);
    run_cmd(0, 3'd4, 9'h100, 36'hF_0F0F_0F0F, 0, 32'h0, 32'h0);

`ifdef LOCALBUS_MASTER_TIMEOUT_EN
    start_cmd(1, 3'd2, 9'h033, 36'h0, -1, 32'h0000000F, 32'hFFFFFFFF, 0);
    finish_cmd(0, 1);
    after_rsp();
    run_cmd(1, 3'd1, 9'h002, 36'h0, 0, 32'h00000003, 32'h0BADBEEF);
`endif

    check("ale_cs_overlap", overlap_viol, 0);
    check("bus_idle_outside", idle_viol, 0);
    check("ready_while_busy", busy_ready, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
